key_entry_buffer: RTL

Receiving end of the keypad encoder's data/load digit stream. It collects BCD digits into a 3-digit M:SS entry register, normalizes invalid seconds (for example 1:75 becomes 2:15), and offers the finished preset to the countdown timer over a valid/ready handshake. It sits between the keypad encoder and the timer's preset inputs, and owns digit count, error flagging and abort-on-clear.

---
 rtl/key_entry_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/key_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : key_entry_buffer
//  Description : Collects BCD digits from the keypad encoder into an M:SS
//                entry register, optionally normalizes seconds-tens 6..9 into
//                minutes, and offers the result to the countdown timer over a
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module key_entry_buffer #(
    parameter int MAX_MIN   = 9,
    parameter bit NORMALIZE = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] data,
    input  logic       load,
    input  logic       clear,
    input  logic       commit,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] mn,
    output logic [3:0] sd,
    output logic [3:0] su,
    output logic [1:0] count,
    output logic       entry_err
);

    typedef enum logic [0:0] {
        ST_ENTRY = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [3:0] c_max_min  = 4'(MAX_MIN);
    localparam logic [3:0] c_max_bcd  = 4'd9;
    localparam logic [3:0] c_six      = 4'd6;
    localparam logic [1:0] c_cnt_full = 2'd3;

    state_t     r_state;
    logic       r_load_q;
    logic       r_armed;
    logic [3:0] r_mn;
    logic [3:0] r_sd;
    logic [3:0] r_su;
    logic [1:0] r_count;
    logic       r_out_valid;
    logic       r_entry_err;

    logic       w_accept;
    logic       w_commit_go;
    logic [1:0] w_count_inc;
    logic [4:0] w_mn_ext;
    logic [3:0] w_norm_mn;
    logic [3:0] w_norm_sd;
    logic [3:0] w_norm_su;

    // A strobe is the first clk of a load high period. The armed bit keeps a
    // load that was already high across reset release from counting as one.
    assign w_accept    = load & ~r_load_q & r_armed;
    assign w_commit_go = commit & (r_count != 2'd0);
    assign w_count_inc = (r_count == c_cnt_full) ? c_cnt_full : r_count + 2'd1;

    // Fold seconds-tens overflow into minutes and saturate above MAX_MIN.
    always_comb begin
        w_mn_ext  = {1'b0, r_mn};
        w_norm_mn = r_mn;
        w_norm_sd = r_sd;
        w_norm_su = r_su;
        if (NORMALIZE) begin
            if (r_sd >= c_six) begin
                w_norm_sd = r_sd - c_six;
                w_mn_ext  = {1'b0, r_mn} + 5'd1;
            end
            if (w_mn_ext > {1'b0, c_max_min}) begin
                w_norm_mn = c_max_min;
                w_norm_sd = 4'd5;
                w_norm_su = 4'd9;
            end else begin
                w_norm_mn = w_mn_ext[3:0];
            end
        end
    end

    // Track the previous load level and arm strobes once load has been low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_load_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_load_q <= load;
            if (!load) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Entry / offer state machine with registered digit and handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_ENTRY;
            r_mn        <= 4'd0;
            r_sd        <= 4'd0;
            r_su        <= 4'd0;
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
            r_entry_err <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_ENTRY;
            r_mn        <= 4'd0;
            r_sd        <= 4'd0;
            r_su        <= 4'd0;
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
            r_entry_err <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_commit_go) begin
                        // Commit wins over a same-cycle strobe; the digit is dropped.
                        r_mn        <= w_norm_mn;
                        r_sd        <= w_norm_sd;
                        r_su        <= w_norm_su;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OFFER;
                    end else if (w_accept) begin
                        if (data <= c_max_bcd) begin
                            r_mn    <= r_sd;
                            r_sd    <= r_su;
                            r_su    <= data;
                            r_count <= w_count_inc;
                        end else begin
                            r_entry_err <= 1'b1;
                        end
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        r_mn        <= 4'd0;
                        r_sd        <= 4'd0;
                        r_su        <= 4'd0;
                        r_count     <= 2'd0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ENTRY;
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign mn        = r_mn;
    assign sd        = r_sd;
    assign su        = r_su;
    assign count     = r_count;
    assign entry_err = r_entry_err;

endmodule
`default_nettype wire
